router_sync_n: RTL and testbench

Parametrised address-latch and channel-synchronisation block for the 1×N router. It sits between the router FSM/register stage and the N output FIFOs. It latches the destination address from the header byte and decodes it into per-FIFO write enables. It muxes back the selected FIFO's full flag, exports per-channel valid-out, and runs a per-channel stall watchdog that soft-resets a FIFO whose consumer stops reading.

---
 rtl/router_pkg.sv | 21 ++
 rtl/router_sync_wdog.sv | 63 ++++++
 rtl/router_sync_n.sv | 93 +++++++++
 tb/tb_router_sync_n.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/router_pkg.sv
`default_nettype none
// ============================================================================
// Module      : router_pkg
// Description : Shared defaults and helpers for the 1xN router sync block.
//               Defining ROUTER_SYNC_WDOG_EN builds the per-channel stall
//               watchdog; leaving it undefined ties soft_reset to 0.
// Revision    : 1.0 - initial release
// ============================================================================
package router_pkg;

    localparam int C_NCH_DEF     = 3;
    localparam int C_AW_DEF      = 2;
    localparam int C_TIMEOUT_DEF = 30;

    // Counter must hold TIMEOUT-1; never narrower than one bit.
    function automatic int cnt_width(input int timeout);
        return (timeout > 2) ? $clog2(timeout) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/router_sync_wdog.sv
`default_nettype none
// ============================================================================
// Module      : router_sync_wdog
// Description : Per-channel stall watchdog; pulses soft_reset_o for one cycle
//               after TIMEOUT consecutive stalled cycles. Built only when
//               ROUTER_SYNC_WDOG_EN is defined, otherwise output is tied to 0.
// Revision    : 1.0 - initial release
// ============================================================================
module router_sync_wdog
    import router_pkg::*;
#(
    parameter int TIMEOUT = C_TIMEOUT_DEF
) (
    input  logic clock,
    input  logic resetn,
    input  logic vld_i,
    input  logic rd_i,
    output logic soft_reset_o
);

`ifdef ROUTER_SYNC_WDOG_EN
    localparam int            CW        = cnt_width(TIMEOUT);
    localparam logic [CW-1:0] C_CNT_MAX = CW'(TIMEOUT - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;
    logic          soft_reset_q;
    logic          soft_reset_d;
    logic          w_stall;

    assign w_stall = vld_i & ~rd_i;

    always_comb begin
        cnt_d        = '0;
        soft_reset_d = 1'b0;
        if (w_stall) begin
            if (cnt_q == C_CNT_MAX) begin
                soft_reset_d = 1'b1;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            cnt_q        <= '0;
            soft_reset_q <= 1'b0;
        end else begin
            cnt_q        <= cnt_d;
            soft_reset_q <= soft_reset_d;
        end
    end

    assign soft_reset_o = soft_reset_q;
`else
    logic w_unused;
    assign w_unused     = ^{clock, resetn, vld_i, rd_i, 1'(TIMEOUT)};
    assign soft_reset_o = 1'b0;
`endif

endmodule
`default_nettype wire

// File: rtl/router_sync_n.sv
`default_nettype none
// ============================================================================
// Module      : router_sync_n
// Description : Destination-address latch, FIFO write-enable decode, full-flag
//               mux and per-channel stall watchdog (ROUTER_SYNC_WDOG_EN).
// Revision    : 1.0 - initial release
// ============================================================================
module router_sync_n
    import router_pkg::*;
#(
    parameter int NCH     = C_NCH_DEF,
    parameter int AW      = C_AW_DEF,
    parameter int TIMEOUT = C_TIMEOUT_DEF
) (
    input  logic           clock,
    input  logic           resetn,
    input  logic           detect_add,
    input  logic [AW-1:0]  data_in,
    input  logic           write_enb_reg,
    input  logic [NCH-1:0] full,
    input  logic [NCH-1:0] empty,
    input  logic [NCH-1:0] read_enb,
    output logic [NCH-1:0] write_enb,
    output logic           fifo_full,
    output logic [NCH-1:0] vld_out,
    output logic [NCH-1:0] soft_reset,
    output logic           addr_err
);

    localparam logic [AW:0] C_NCH_W = (AW + 1)'(NCH);

    logic [AW-1:0] addr_q;
    logic [AW-1:0] addr_d;
    logic          addr_vld_q;
    logic          addr_vld_d;
    logic          addr_err_q;
    logic          addr_err_d;
    logic          w_sel_full;

    always_comb begin
        addr_d     = addr_q;
        addr_vld_d = addr_vld_q;
        addr_err_d = addr_err_q;
        if (detect_add) begin
            addr_d     = data_in;
            addr_vld_d = ({1'b0, data_in} < C_NCH_W);
            addr_err_d = ~addr_vld_d;
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            addr_q     <= '1;
            addr_vld_q <= 1'b0;
            addr_err_q <= 1'b0;
        end else begin
            addr_q     <= addr_d;
            addr_vld_q <= addr_vld_d;
            addr_err_q <= addr_err_d;
        end
    end

    // Decode uses the registered address, so a header arriving alongside a
    // write still steers that write by the previous destination.
    always_comb begin
        write_enb  = '0;
        w_sel_full = 1'b0;
        for (int i = 0; i < NCH; i++) begin
            if (addr_q == AW'(i)) begin
                write_enb[i] = write_enb_reg & addr_vld_q;
                w_sel_full   = full[i];
            end
        end
    end

    assign fifo_full = addr_vld_q ? w_sel_full : 1'b1;
    assign vld_out   = ~empty;
    assign addr_err  = addr_err_q;

    for (genvar gi = 0; gi < NCH; gi++) begin : g_wdog
        router_sync_wdog #(
            .TIMEOUT (TIMEOUT)
        ) u_wdog (
            .clock        (clock),
            .resetn       (resetn),
            .vld_i        (vld_out[gi]),
            .rd_i         (read_enb[gi]),
            .soft_reset_o (soft_reset[gi])
        );
    end

endmodule
`default_nettype wire

// File: tb/tb_router_sync_n.sv
`default_nettype none
// ============================================================================
// Module      : tb_router_sync_n
// Description : Scoreboard bench for router_sync_n (NCH=3, AW=2, TIMEOUT=30).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_router_sync_n;

    localparam int K_WE  = 0;
    localparam int K_FF  = 1;
    localparam int K_VLD = 2;
    localparam int K_SR  = 3;
    localparam int K_ERR = 4;
`ifdef ROUTER_SYNC_WDOG_EN
    localparam bit WDOG = 1'b1;
`else
    localparam bit WDOG = 1'b0;
`endif

    logic       clock;
    logic       resetn;
    logic       detect_add;
    logic [1:0] data_in;
    logic       write_enb_reg;
    logic [2:0] full;
    logic [2:0] empty;
    logic [2:0] read_enb;
    logic [2:0] write_enb;
    logic       fifo_full;
    logic [2:0] vld_out;
    logic [2:0] soft_reset;
    logic       addr_err;

    typedef struct {
        int          cyc;
        int          kind;
        logic [15:0] exp;
        string       tag;
    } exp_t;

    exp_t sb[$];
    int   cyc    = 0;
    int   n_vec  = 0;
    int   n_err  = 0;

    router_sync_n #(
        .NCH     (3),
        .AW      (2),
        .TIMEOUT (30)
    ) dut (
        .clock         (clock),
        .resetn        (resetn),
        .detect_add    (detect_add),
        .data_in       (data_in),
        .write_enb_reg (write_enb_reg),
        .full          (full),
        .empty         (empty),
        .read_enb      (read_enb),
        .write_enb     (write_enb),
        .fifo_full     (fifo_full),
        .vld_out       (vld_out),
        .soft_reset    (soft_reset),
        .addr_err      (addr_err)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    initial forever begin
        @(posedge clock);
        cyc++;
    end

    function automatic logic [15:0] actual(input int kind);
        case (kind)
            K_WE:    return 16'(write_enb);
            K_FF:    return 16'(fifo_full);
            K_VLD:   return 16'(vld_out);
            K_SR:    return 16'(soft_reset);
            default: return 16'(addr_err);
        endcase
    endfunction

    // Monitor: pops every expectation due this cycle and compares mid-cycle.
    initial forever begin
        exp_t        it;
        logic [15:0] act;
        @(negedge clock);
        while (sb.size() > 0 && sb[0].cyc <= cyc) begin
            it  = sb.pop_front();
            act = actual(it.kind);
            n_vec++;
            if (it.cyc != cyc || act !== it.exp) begin
                n_err++;
                $display("FAIL %s: actual %h, required %h (cycle %0d, due %0d)",
                         it.tag, act, it.exp, cyc, it.cyc);
            end
        end
    end

    task automatic tick();
        @(posedge clock);
        #2;
    endtask

    task automatic sb_push(input int kind, input logic [15:0] v, input string tag);
        exp_t e;
        e.cyc  = cyc;
        e.kind = kind;
        e.exp  = v;
        e.tag  = tag;
        sb.push_back(e);
    endtask

    // Channel 1 stalls for n cycles (read strobe at rd_at, reset pulse at
    // rst_at); soft_reset expected 3'b010 at cycle offsets p0/p1/p2 only.
    task automatic wd_run(input int n, input int rd_at, input int rst_at,
                          input int p0, input int p1, input int p2, input string tag);
        for (int j = 0; j <= n; j++) begin
            tick();
            if (j < n) begin
                empty    = 3'b101;
                read_enb = (j == rd_at) ? 3'b010 : 3'b000;
            end else begin
                empty    = 3'b111;
                read_enb = 3'b000;
            end
            sb_push(K_SR, (WDOG && (j == p0 || j == p1 || j == p2)) ? 16'h2 : 16'h0, tag);
            if (j == rst_at) begin
                resetn = 1'b0;
                sb_push(K_FF, 16'h1, {tag, "_ff_in_reset"});
                #5;
                resetn = 1'b1;
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: actual running, required finished");
        $fatal(1);
    end

    initial begin
        resetn        = 1'b0;
        detect_add    = 1'b0;
        data_in       = 2'd0;
        write_enb_reg = 1'b1;
        full          = 3'b000;
        empty         = 3'b111;
        read_enb      = 3'b000;

        tick();
        sb_push(K_WE,  16'h0, "rst_we");
        sb_push(K_FF,  16'h1, "rst_ff");
        sb_push(K_ERR, 16'h0, "rst_err");
        sb_push(K_SR,  16'h0, "rst_sr");
        sb_push(K_VLD, 16'h0, "rst_vld");
        tick();
        resetn = 1'b1;
        sb_push(K_WE,  16'h0, "post_rst_we");

        tick(); detect_add = 1'b1; data_in = 2'd2; full = 3'b011;
        sb_push(K_WE, 16'h0, "hdr2_same_cycle_we");
        sb_push(K_FF, 16'h1, "hdr2_same_cycle_ff");
        tick(); detect_add = 1'b0;
        sb_push(K_WE,  16'h4, "addr2_we");
        sb_push(K_FF,  16'h0, "addr2_ff_clear");
        sb_push(K_ERR, 16'h0, "addr2_err");
        tick(); full = 3'b100;
        sb_push(K_FF, 16'h1, "addr2_ff_set");
        sb_push(K_WE, 16'h4, "addr2_we_hold");
        tick(); write_enb_reg = 1'b0;
        sb_push(K_WE, 16'h0, "addr2_no_req");

        tick(); detect_add = 1'b1; data_in = 2'd3; write_enb_reg = 1'b1;
        sb_push(K_WE,  16'h4, "hdr3_uses_old_addr");
        sb_push(K_ERR, 16'h0, "hdr3_err_not_yet");
        tick(); detect_add = 1'b0; full = 3'b000;
        sb_push(K_ERR, 16'h1, "addr3_err");
        sb_push(K_WE,  16'h0, "addr3_we_dropped");
        sb_push(K_FF,  16'h1, "addr3_ff_forced");

        tick(); detect_add = 1'b1; data_in = 2'd0;
        sb_push(K_WE, 16'h0, "hdr0_old_invalid");
        tick(); detect_add = 1'b0; full = 3'b001;
        sb_push(K_ERR, 16'h0, "addr0_err_clear");
        sb_push(K_WE,  16'h1, "addr0_we");
        sb_push(K_FF,  16'h1, "addr0_ff_set");
        tick(); full = 3'b110;
        sb_push(K_FF, 16'h0, "addr0_ff_clear");

        tick(); detect_add = 1'b1; data_in = 2'd1; write_enb_reg = 1'b0;
        sb_push(K_WE, 16'h0, "hdr1_no_req");
        tick(); detect_add = 1'b0; data_in = 2'd2; write_enb_reg = 1'b1; full = 3'b010;
        sb_push(K_WE, 16'h2, "addr1_we");
        sb_push(K_FF, 16'h1, "addr1_ff");
        tick(); empty = 3'b010;
        sb_push(K_VLD, 16'h5, "vld_101");
        sb_push(K_WE,  16'h2, "addr1_hold");
        tick(); empty = 3'b101;
        sb_push(K_VLD, 16'h2, "vld_010");
        tick(); empty = 3'b111; write_enb_reg = 1'b0;
        sb_push(K_VLD, 16'h0, "vld_000");
        tick();
        tick();

        wd_run(100, -1, -1, 30, 60, 90, "wd_hold");
        wd_run(60,  29, -1, 60, -1, -1, "wd_read_rescue");
        wd_run(55,  -1, 20, 50, -1, -1, "wd_reset_mid");

        for (int i = 0; i < 20 && sb.size() > 0; i++) @(posedge clock);
        if (sb.size() > 0) begin
            n_vec++;
            n_err++;
            $display("FAIL sb_drain: actual %0d pending, required 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
